// File: rtl/lsu.sv
// Load/store unit: request/grant/response handshake to a multi-cycle data memory.
// Optional abort of stalled accesses when LSU_TIMEOUT_EN is defined (limit = TIMEOUT cycles).
module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_trap,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        wen_q;
  logic [1:0]  off_in;
  logic        bad_in;
  logic [3:0]  mask_in;
  logic [31:0] wdata_in;
  logic [31:0] rd_sh;
  logic [31:0] ld_data;
  logic        accept;
  logic        to_hit;

  assign off_in   = i_req_addr[1:0];
  assign accept   = i_req_valid & o_req_ready;
  assign wdata_in = i_req_wdata << {off_in, 3'b000};
  assign rd_sh    = i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    bad_in  = 1'b0;
    mask_in = 4'b1111;
    case (i_req_size)
      2'b00:   mask_in = 4'b0001 << off_in;
      2'b01: begin
        mask_in = 4'b0011 << off_in;
        bad_in  = off_in[0];
      end
      2'b10:   bad_in = |off_in;
      default: bad_in = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = rd_sh;
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   ld_data = {{16{~uns_q & rd_sh[15]}}, rd_sh[15:0]};
      default: ld_data = rd_sh;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt;

  // cnt holds the number of REQ/WAIT cycles already completed, so the abort
  // fires during the TIMEOUT-th cycle and takes priority over gnt/rvalid.
  assign to_hit = (state == REQ || state == WAIT) && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                            cnt <= '0;
    else if (accept)                      cnt <= '0;
    else if (state == REQ || state == WAIT) cnt <= cnt + 8'd1;
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_trap  <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wen   <= 1'b0;
      o_mem_wdata <= '0;
      o_mem_mask  <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wen_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_req_ready <= 1'b0;
            off_q       <= off_in;
            size_q      <= i_req_size;
            uns_q       <= i_req_unsigned;
            wen_q       <= i_req_wen;
            if (bad_in) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_trap  <= 1'b1;
            end else begin
              state       <= REQ;
              o_mem_req   <= 1'b1;
              o_mem_addr  <= {i_req_addr[31:2], 2'b00};
              o_mem_wen   <= i_req_wen;
              o_mem_wdata <= i_req_wen ? wdata_in : '0;
              o_mem_mask  <= mask_in;
            end
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        REQ: begin
          if (to_hit) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_trap  <= 1'b1;
          end else if (i_mem_gnt) begin
            state <= WAIT;
          end
          if (to_hit || i_mem_gnt) begin
            o_mem_req   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
          end
        end
        WAIT: begin
          if (to_hit) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_trap  <= 1'b1;
          end else if (i_mem_rvalid) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= wen_q ? '0 : ld_data;
          end
        end
        RESP: begin
          state       <= IDLE;
          o_rsp_valid <= 1'b0;
          o_rsp_rdata <= '0;
          o_rsp_trap  <= 1'b0;
          o_req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses against
// an arithmetic reference model. Timeout scenarios apply when LSU_TIMEOUT_EN is defined.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wen;
  logic [31:0] i_req_addr;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_trap;
  logic        o_mem_req;
  logic        i_mem_gnt;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  lsu #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wen(i_req_wen), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_trap(o_rsp_trap),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_addr(o_mem_addr),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  // Reference model: g = cycles gnt is withheld, r = cycles between gnt and rvalid.
  function automatic void model(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata, input logic [31:0] mw,
                                input int g, input int r,
                                output logic trap, output logic [3:0] mask, output logic [31:0] mwd,
                                output logic [31:0] rd, output int lat, output int reqc);
    int unsigned off;
    int unsigned nb;
    longint v;
    int c;
    off  = addr % 4;
    nb   = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
    trap = (nb == 0) || (off % nb != 0);
    mask = (nb == 0) ? 4'b0 : 4'(((1 << nb) - 1) << off);
    mwd  = wen ? 32'(64'(wdata) * (64'd1 << (8 * off))) : 32'h0;
    rd   = 32'h0;
    if (nb != 0) begin
      v = (longint'(mw) >> (8 * off)) % (longint'(1) << (8 * nb));
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      rd = 32'(v);
    end
    if (wen || trap) rd = 32'h0;
    if (trap) begin
      lat  = 1;
      reqc = 0;
    end else begin
      c    = g + r + 2;
      lat  = c + 1;
      reqc = g + 1;
`ifdef LSU_TIMEOUT_EN
      if (c >= int'(TO)) begin
        trap = 1'b1;
        rd   = 32'h0;
        lat  = TO + 1;
        reqc = (g + 1 < int'(TO)) ? g + 1 : int'(TO);
      end
`endif
    end
  endfunction

  // Drives one access and plays the memory; called at a negedge, returns at the negedge after RESP.
  task automatic run_access(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata, input int g, input int r,
                            input logic [31:0] mw, input bit noise,
                            output int lat, output logic [31:0] rd, output logic trap, output int reqc,
                            output logic [31:0] maddr, output logic [31:0] mwd, output logic [3:0] mmask,
                            output logic mwen, output bit stable, output bit idle_zero, output logic rdy_at_rsp);
    int phase;
    int j;
    int w;
    lat = -1; rd = '0; trap = 1'b0; reqc = 0; maddr = '0; mwd = '0; mmask = '0; mwen = 1'b0;
    stable = 1'b1; idle_zero = 1'b1; rdy_at_rsp = 1'b0; phase = 0; j = 0;
    w = 0;
    while (!o_req_ready && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr; i_req_size = size;
    i_req_unsigned = uns; i_req_wdata = wdata;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_wen = 1'($urandom); i_req_addr = $urandom;
    i_req_size = 2'($urandom); i_req_unsigned = 1'($urandom); i_req_wdata = $urandom;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = $urandom;
      if (o_rsp_valid) begin
        lat = n; rd = o_rsp_rdata; trap = o_rsp_trap; rdy_at_rsp = o_req_ready;
      end else if (o_mem_req) begin
        if (reqc == 0) begin
          maddr = o_mem_addr; mwd = o_mem_wdata; mmask = o_mem_mask; mwen = o_mem_wen;
        end else if (o_mem_addr !== maddr || o_mem_wdata !== mwd || o_mem_mask !== mmask || o_mem_wen !== mwen) begin
          stable = 1'b0;
        end
        if (reqc >= g) begin
          i_mem_gnt = 1'b1;
          phase = 1;
        end
        reqc++;
        if (noise) i_mem_rvalid = 1'($urandom_range(0, 1));
      end else begin
        if ({o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wen} != '0) idle_zero = 1'b0;
        if (phase == 1) begin
          if (j == r) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = mw;
          end else if (noise) begin
            i_mem_gnt = 1'($urandom_range(0, 1));
          end
          j++;
        end
      end
      @(negedge i_clk);
    end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0; i_req_size = '0;
    i_req_unsigned = 1'b0; i_req_wdata = '0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap, o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rsp_valid=%b mem_req=%b, required all zero", o_req_ready, o_rsp_valid, o_mem_req);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_release: got %b required 0", o_req_ready);
    end
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 1", o_req_ready);
    end
  endtask

  task automatic test_load_byte();
    int lat, reqc; logic [31:0] rd, maddr, mwd; logic trap, mwen, rdy; logic [3:0] mmask; bit st, iz;
    run_access(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 0, 0, 32'h80FF7F01, 1'b0,
               lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
    checks++;
    if (lat !== 3 || rd !== 32'hFFFFFF80 || trap !== 1'b0) begin
      errors++;
      $display("FAIL lb_rsp: got lat=%0d rdata=%h trap=%b required lat=3 rdata=ffffff80 trap=0", lat, rd, trap);
    end
    checks++;
    if (maddr !== 32'h100 || mmask !== 4'b1000 || mwen !== 1'b0 || reqc !== 1) begin
      errors++;
      $display("FAIL lb_mem: got addr=%h mask=%b wen=%b reqc=%0d required addr=100 mask=1000 wen=0 reqc=1", maddr, mmask, mwen, reqc);
    end
  endtask

  task automatic test_load_half();
    int lat, reqc; logic [31:0] rd, maddr, mwd; logic trap, mwen, rdy; logic [3:0] mmask; bit st, iz;
    logic [31:0] exp_rd [2];
    exp_rd[0] = 32'h000080FF;
    exp_rd[1] = 32'hFFFF80FF;
    for (int k = 0; k < 2; k++) begin
      run_access(1'b0, 32'h102, 2'b01, (k == 0), 32'h0, 0, 0, 32'h80FF7F01, 1'b0,
                 lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
      checks++;
      if (rd !== exp_rd[k] || trap !== 1'b0 || lat !== 3) begin
        errors++;
        $display("FAIL lh_rsp[%0d]: got rdata=%h trap=%b lat=%0d required rdata=%h trap=0 lat=3", k, rd, trap, lat, exp_rd[k]);
      end
      checks++;
      if (mmask !== 4'b1100 || maddr !== 32'h100) begin
        errors++;
        $display("FAIL lh_mem[%0d]: got mask=%b addr=%h required mask=1100 addr=100", k, mmask, maddr);
      end
    end
  endtask

  task automatic test_store_backpressure();
    int lat, reqc, elat, ereqc; logic [31:0] rd, maddr, mwd, erd, emwd; logic trap, mwen, rdy, etrap;
    logic [3:0] mmask, emask; bit st, iz;
    model(1'b1, 32'h201, 2'b00, 1'b0, 32'hAB, 32'h0, 3, 0, etrap, emask, emwd, erd, elat, ereqc);
    run_access(1'b1, 32'h201, 2'b00, 1'b0, 32'h000000AB, 3, 0, 32'hDEADBEEF, 1'b1,
               lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
    checks++;
    if (mwd !== 32'h0000AB00 || mmask !== 4'b0010 || mwen !== 1'b1 || maddr !== 32'h200) begin
      errors++;
      $display("FAIL sb_mem: got wdata=%h mask=%b wen=%b addr=%h required 0000ab00 0010 1 00000200", mwd, mmask, mwen, maddr);
    end
    checks++;
    if (reqc !== 4 || st !== 1'b1) begin
      errors++;
      $display("FAIL sb_stable: got req_cycles=%0d stable=%b required 4 and 1", reqc, st);
    end
    checks++;
    if (rd !== 32'h0 || trap !== etrap || lat !== elat) begin
      errors++;
      $display("FAIL sb_rsp: got rdata=%h trap=%b lat=%0d required 0 %b %0d", rd, trap, lat, etrap, elat);
    end
  endtask

  task automatic test_misaligned();
    int lat, reqc; logic [31:0] rd, maddr, mwd; logic trap, mwen, rdy; logic [3:0] mmask; bit st, iz;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h302; sizes[0] = 2'b10;
    addrs[1] = 32'h301; sizes[1] = 2'b01;
    addrs[2] = 32'h300; sizes[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      run_access(1'($urandom), addrs[k], sizes[k], 1'b0, $urandom, 0, 0, $urandom, 1'b0,
                 lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
      checks++;
      if (lat !== 1 || trap !== 1'b1 || rd !== 32'h0 || reqc !== 0) begin
        errors++;
        $display("FAIL misaligned[%0d]: got lat=%0d trap=%b rdata=%h req_cycles=%0d required 1 1 0 0", k, lat, trap, rd, reqc);
      end
    end
  endtask

  task automatic test_random();
    int lat, reqc, elat, ereqc, g, r; logic [31:0] rd, maddr, mwd, erd, emwd, addr, wdata, mw;
    logic trap, mwen, rdy, etrap, wen, uns; logic [3:0] mmask, emask; logic [1:0] size; bit st, iz;
    for (int k = 0; k < 60; k++) begin
      wen = 1'($urandom); uns = 1'($urandom); addr = $urandom; wdata = $urandom; mw = $urandom;
      size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      g = $urandom_range(0, 3); r = $urandom_range(0, 3);
      model(wen, addr, size, uns, wdata, mw, g, r, etrap, emask, emwd, erd, elat, ereqc);
      run_access(wen, addr, size, uns, wdata, g, r, mw, 1'b1,
                 lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
      checks++;
      if (lat !== elat || rd !== erd || trap !== etrap) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got lat=%0d rdata=%h trap=%b required lat=%0d rdata=%h trap=%b", k, lat, rd, trap, elat, erd, etrap);
      end
      checks++;
      if (reqc !== ereqc || st !== 1'b1 || iz !== 1'b1) begin
        errors++;
        $display("FAIL rand_req[%0d]: got req_cycles=%0d stable=%b idle_zero=%b required %0d 1 1", k, reqc, st, iz, ereqc);
      end
      if (ereqc > 0) begin
        checks++;
        if (maddr !== {addr[31:2], 2'b00} || mmask !== emask || mwd !== emwd || mwen !== wen) begin
          errors++;
          $display("FAIL rand_mem[%0d]: got addr=%h mask=%b wdata=%h wen=%b required %h %b %h %b", k, maddr, mmask, mwd, mwen, {addr[31:2], 2'b00}, emask, emwd, wen);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, reqc; logic [31:0] rd, maddr, mwd; logic trap, mwen, rdy; logic [3:0] mmask; bit st, iz;
    for (int k = 0; k < 4; k++) begin
      run_access(1'b0, 32'h500 + 32'(k), 2'b00, 1'b1, 32'h0, 0, 0, 32'h44332211, 1'b0,
                 lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
      checks++;
      if (rdy !== 1'b0 || o_req_ready !== 1'b1 || rd !== 32'(k + 1) * 32'h11) begin
        errors++;
        $display("FAIL b2b[%0d]: got ready_in_resp=%b ready_after=%b rdata=%h required 0 1 %h", k, rdy, o_req_ready, rd, 32'(k + 1) * 32'h11);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, reqc, seen; logic [31:0] rd, maddr, mwd; logic trap, mwen, rdy; logic [3:0] mmask; bit st, iz;
    for (int k = 0; k < 2; k++) begin
      i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_addr = 32'h400; i_req_size = 2'b10; i_req_unsigned = 1'b0;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      if (k == 1) begin
        i_mem_gnt = 1'b1;
        @(negedge i_clk);
        i_mem_gnt = 1'b0;
      end
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_mem_req !== 1'b0 || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got mem_req=%b rsp_valid=%b ready=%b required 0 0 0", k, o_mem_req, o_rsp_valid, o_req_ready);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      seen = 0;
      for (int n = 0; n < 4; n++) begin
        if (o_rsp_valid) seen++;
        @(negedge i_clk);
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL reset_discard[%0d]: got %0d responses required 0", k, seen);
      end
      run_access(1'b0, 32'h404, 2'b10, 1'b0, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0,
                 lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
      checks++;
      if (rd !== 32'hCAFEF00D || trap !== 1'b0 || lat !== 5) begin
        errors++;
        $display("FAIL reset_recover[%0d]: got rdata=%h trap=%b lat=%0d required cafef00d 0 5", k, rd, trap, lat);
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int lat, reqc, seen; logic [31:0] rd, maddr, mwd; logic trap, mwen, rdy; logic [3:0] mmask; bit st, iz;
    run_access(1'b0, 32'h600, 2'b10, 1'b0, 32'h0, 1000, 0, 32'h0, 1'b0,
               lat, rd, trap, reqc, maddr, mwd, mmask, mwen, st, iz, rdy);
    checks++;
    if (lat !== 5 || trap !== 1'b1 || rd !== 32'h0 || reqc !== 4) begin
      errors++;
      $display("FAIL timeout: got lat=%0d trap=%b rdata=%h req_cycles=%0d required 5 1 0 4", lat, trap, rd, reqc);
    end
    seen = 0;
    i_mem_rvalid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if (o_rsp_valid || o_mem_req) seen++;
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL timeout_after: got %0d cycles with rsp_valid or mem_req required 0", seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_backpressure();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
